// File: rtl/scan_doubler_pkg.sv
// Shared pixel type and default timing for the scan doubler.
// Defaults describe a 384-clk output line with 256 active pixels.
package scan_doubler_pkg;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  localparam int DEF_H_ACTIVE = 256;
  localparam int DEF_H_TOTAL  = 384;
  localparam int DEF_HS_START = 288;
  localparam int DEF_HS_LEN   = 32;
  localparam int DEF_ADDR_W   = 9;

endpackage

// File: rtl/scan_doubler_if.sv
// Pixel-in / video-out bundle between the palette stage, scan doubler and encoder.
// master = the surrounding system, slave = the scan doubler.
interface scan_doubler_if;

  logic       pix_ce;
  logic       in_valid;
  logic [2:0] in_r;
  logic [2:0] in_g;
  logic [1:0] in_b;
  logic       in_hsync;
  logic       in_vsync;

  logic [2:0] out_r;
  logic [2:0] out_g;
  logic [1:0] out_b;
  logic       out_de;
  logic       out_hsync;
  logic       out_vsync;

  modport master (
    output pix_ce, in_valid, in_r, in_g, in_b, in_hsync, in_vsync,
    input  out_r, out_g, out_b, out_de, out_hsync, out_vsync
  );

  modport slave (
    input  pix_ce, in_valid, in_r, in_g, in_b, in_hsync, in_vsync,
    output out_r, out_g, out_b, out_de, out_hsync, out_vsync
  );

endinterface

// File: rtl/scan_doubler_line_buffer.sv
// Ping-pong line store: simple dual-port RAM, bank selected by the address MSB.
// Synchronous write, registered read with one clock of latency.
module scan_doubler_line_buffer
  import scan_doubler_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [ADDR_W:0] waddr_i,
  input  rgb332_t         wdata_i,
  input  logic [ADDR_W:0] raddr_i,
  output rgb332_t         rdata_o
);

  localparam int DEPTH = 2 ** (ADDR_W + 1);

  rgb332_t mem_q [DEPTH];
  rgb332_t rdata_q;

  // NOTE: the array has no reset so it maps onto block RAM; stale contents are
  // masked downstream by the stored line length.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/scan_doubler.sv
// Line-doubling scan converter: stores each input line at 1 pixel / 2 clk and
// replays it twice at 1 pixel / clk with its own sync timing, 2 clk pipeline.
module scan_doubler
  import scan_doubler_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int HS_START = DEF_HS_START,
  parameter int HS_LEN   = DEF_HS_LEN,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input logic           clk,
  input logic           rst_n,
  scan_doubler_if.slave vif
);

  localparam int              HC_W   = $clog2(H_TOTAL);
  localparam logic [ADDR_W:0] WR_MAX = (ADDR_W + 1)'(H_ACTIVE);
  localparam logic [HC_W-1:0] H_LAST = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] DE_END = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] HS_LO  = HC_W'(HS_START);
  localparam logic [HC_W-1:0] HS_HI  = HC_W'(HS_START + HS_LEN);

  logic            hs_q;
  logic            vs_lat_q,  vs_lat_d;
  logic            wr_bank_q, wr_bank_d;
  logic            line_ok_q, line_ok_d;
  logic [ADDR_W:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W:0] rd_len_q,  rd_len_d;
  logic [HC_W-1:0] h_cnt_q,   h_cnt_d;
  logic [ADDR_W:0] wr_idx;
  logic            line_start;
  logic            wr_en;
  rgb332_t         wr_pix;
  rgb332_t         rd_pix;

  logic            de_p_q, hs_p_q, vs_p_q, pix_ok_p_q;
  rgb332_t         out_pix_q;
  logic            out_de_q, out_hs_q, out_vs_q;

  assign line_start = vif.in_hsync & ~hs_q;
  assign wr_pix     = {vif.in_r, vif.in_g, vif.in_b};

  // NOTE: every output of this block is given a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_addr_d = wr_addr_q;
    rd_len_d  = rd_len_q;
    line_ok_d = line_ok_q;
    vs_lat_d  = vs_lat_q;
    h_cnt_d   = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 1'b1;
    wr_idx    = wr_addr_q;
    wr_en     = 1'b0;

    if (line_start) begin
      wr_bank_d = ~wr_bank_q;
      rd_len_d  = wr_addr_q;
      line_ok_d = 1'b1;
      vs_lat_d  = vif.in_vsync;
      h_cnt_d   = '0;
      wr_addr_d = '0;
      wr_idx    = '0;
    end

    // A pixel arriving with the line start lands at address 0 of the new bank.
    if (vif.pix_ce && vif.in_valid && (wr_idx < WR_MAX)) begin
      wr_en     = 1'b1;
      wr_addr_d = wr_idx + 1'b1;
    end
  end

  scan_doubler_line_buffer #(.ADDR_W(ADDR_W)) u_line_buffer (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i ({wr_bank_d, wr_idx[ADDR_W-1:0]}),
    .wdata_i (wr_pix),
    .raddr_i ({~wr_bank_q, ADDR_W'(h_cnt_q)}),
    .rdata_o (rd_pix)
  );

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q       <= 1'b0;
      vs_lat_q   <= 1'b0;
      wr_bank_q  <= 1'b0;
      line_ok_q  <= 1'b0;
      wr_addr_q  <= '0;
      rd_len_q   <= '0;
      h_cnt_q    <= '0;
      de_p_q     <= 1'b0;
      hs_p_q     <= 1'b0;
      vs_p_q     <= 1'b0;
      pix_ok_p_q <= 1'b0;
      out_pix_q  <= '0;
      out_de_q   <= 1'b0;
      out_hs_q   <= 1'b0;
      out_vs_q   <= 1'b0;
    end else begin
      hs_q       <= vif.in_hsync;
      vs_lat_q   <= vs_lat_d;
      wr_bank_q  <= wr_bank_d;
      line_ok_q  <= line_ok_d;
      wr_addr_q  <= wr_addr_d;
      rd_len_q   <= rd_len_d;
      h_cnt_q    <= h_cnt_d;
      // Stage 1 runs alongside the RAM read; stage 2 is the output register.
      de_p_q     <= h_cnt_q < DE_END;
      hs_p_q     <= (h_cnt_q >= HS_LO) && (h_cnt_q < HS_HI);
      vs_p_q     <= vs_lat_q;
      pix_ok_p_q <= line_ok_q && ((ADDR_W + 1)'(h_cnt_q) < rd_len_q);
      out_pix_q  <= (de_p_q && pix_ok_p_q) ? rd_pix : '0;
      out_de_q   <= de_p_q;
      out_hs_q   <= hs_p_q;
      out_vs_q   <= vs_p_q;
    end
  end

  assign vif.out_r     = out_pix_q.r;
  assign vif.out_g     = out_pix_q.g;
  assign vif.out_b     = out_pix_q.b;
  assign vif.out_de    = out_de_q;
  assign vif.out_hsync = out_hs_q;
  assign vif.out_vsync = out_vs_q;

endmodule

// File: tb/tb_scan_doubler.sv
// Directed bench for scan_doubler: table of stored-line scenarios replayed and
// compared cycle by cycle, plus hand-written reset, early-sync and collision cases.
module tb_scan_doubler;

  localparam int H_TOTAL = 384;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   cyc;

  scan_doubler_if vif ();

  scan_doubler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         n_pix;
    logic [7:0] key;
    logic       vs;
    int         exp_len;
    int         n_lines;
    int         exp_de;
    int         exp_hs;
  } vec_t;

  vec_t vecs[4];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [10:0] outs();
    return {vif.out_r, vif.out_g, vif.out_b, vif.out_de, vif.out_hsync, vif.out_vsync};
  endfunction

  // Pixels past the 256-entry line get a different code so an overwrite shows up.
  function automatic logic [7:0] pix_val(int i, logic [7:0] key);
    logic [7:0] lo;
    lo = i[7:0];
    return (i < 256) ? (lo ^ key) : (lo ^ key ^ 8'h5A);
  endfunction

  task automatic write_line(int n, logic [7:0] key);
    for (int i = 0; i < n; i++) begin
      if (i % 16 == 5) begin
        vif.pix_ce = 1'b1; vif.in_valid = 1'b0;
        {vif.in_r, vif.in_g, vif.in_b} = 8'hFF;
        step();
        vif.pix_ce = 1'b0;
        step();
      end
      vif.pix_ce = 1'b1; vif.in_valid = 1'b1;
      {vif.in_r, vif.in_g, vif.in_b} = pix_val(i, key);
      step();
      vif.pix_ce = 1'b0; vif.in_valid = 1'b0;
      step();
    end
  endtask

  // Sets a one-cycle in_hsync pulse; returns one cycle after the detect cycle.
  task automatic hsync_pulse(logic vs, logic with_pix, logic [7:0] px);
    vif.in_hsync = 1'b1;
    vif.in_vsync = vs;
    if (with_pix) begin
      vif.pix_ce = 1'b1; vif.in_valid = 1'b1;
      {vif.in_r, vif.in_g, vif.in_b} = px;
    end
    step();
    vif.in_hsync = 1'b0;
    vif.pix_ce   = 1'b0;
    vif.in_valid = 1'b0;
  endtask

  task automatic check_lines(string tag, int n_lines, int exp_len, logic [7:0] key,
                             logic vs, int exp_de, int exp_hs);
    int         de_cnt;
    int         hs_cnt;
    int         h;
    logic [7:0] px;
    logic [10:0] o;
    de_cnt = 0;
    hs_cnt = 0;
    step();
    step();
    for (int j = 0; j < n_lines * H_TOTAL; j++) begin
      h  = j % H_TOTAL;
      px = (h < 256 && h < exp_len) ? pix_val(h, key) : 8'h00;
      o  = outs();
      check($sformatf("%s line%0d h=%0d", tag, j / H_TOTAL, h), 32'(o),
            32'({px, (h < 256), (h >= 288 && h < 320), vs}));
      de_cnt += int'(o[2]);
      hs_cnt += int'(o[1]);
      step();
    end
    check($sformatf("%s de_count", tag), de_cnt, exp_de);
    check($sformatf("%s hs_count", tag), hs_cnt, exp_hs);
  endtask

  task automatic check_black_line(string tag);
    int de_cnt;
    de_cnt = 0;
    for (int j = 0; j < H_TOTAL; j++) begin
      check($sformatf("%s rgb j=%0d", tag, j), 32'(outs() >> 3), 32'd0);
      de_cnt += int'(vif.out_de);
      step();
    end
    check($sformatf("%s de_count", tag), de_cnt, 256);
  endtask

  initial begin
    int t1;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;

    vecs[0] = '{"ramp",     256, 8'h00, 1'b1, 256, 2, 512, 64};
    vecs[1] = '{"overflow", 300, 8'hA5, 1'b0, 256, 2, 512, 64};
    vecs[2] = '{"short",    100, 8'h3C, 1'b1, 100, 3, 768, 96};
    vecs[3] = '{"empty",      0, 8'h00, 1'b0,   0, 1, 256, 32};

    rst_n        = 1'b0;
    vif.pix_ce   = 1'b0;
    vif.in_valid = 1'b0;
    vif.in_r     = '0;
    vif.in_g     = '0;
    vif.in_b     = '0;
    vif.in_hsync = 1'b0;
    vif.in_vsync = 1'b0;

    step();
    step();
    check("reset outputs", 32'(outs()), 32'd0);
    rst_n = 1'b1;
    step();
    check_black_line("post-reset");

    for (int v = 0; v < 4; v++) begin
      write_line(vecs[v].n_pix, vecs[v].key);
      hsync_pulse(vecs[v].vs, 1'b0, 8'h00);
      check_lines(vecs[v].name, vecs[v].n_lines, vecs[v].exp_len, vecs[v].key,
                  vecs[v].vs, vecs[v].exp_de, vecs[v].exp_hs);
    end

    // Pixel coinciding with the line start goes to address 0 of the new bank.
    write_line(10, 8'h66);
    hsync_pulse(1'b1, 1'b1, pix_val(0, 8'hE7));
    check_lines("collide-prev", 1, 10, 8'h66, 1'b1, 256, 32);
    hsync_pulse(1'b1, 1'b0, 8'h00);
    check_lines("collide-new", 1, 1, 8'hE7, 1'b1, 256, 32);

    // Second line start 100 clk after the first restarts the output line.
    write_line(60, 8'h11);
    t1 = cyc;
    hsync_pulse(1'b0, 1'b0, 8'h00);
    step();
    step();
    check("early first pixel", 32'(outs()), 32'({pix_val(0, 8'h11), 1'b1, 1'b0, 1'b0}));
    write_line(40, 8'h22);
    while (cyc < t1 + 100) step();
    hsync_pulse(1'b0, 1'b0, 8'h00);
    check_lines("early", 1, 40, 8'h22, 1'b0, 256, 32);

    // Reset mid-line: outputs drop at once, next line is black.
    write_line(20, 8'h40);
    hsync_pulse(1'b1, 1'b0, 8'h00);
    repeat (12) step();
    check("pre-reset pixel", 32'(outs()), 32'({pix_val(10, 8'h40), 1'b1, 1'b0, 1'b1}));
    rst_n = 1'b0;
    #1;
    check("async reset outputs", 32'(outs()), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check_black_line("mid-reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
